// File: rtl/debug_ocimem_ctrl_pkg.sv
// debug_ocimem_ctrl_pkg: FSM states, jdo field positions and fill constants shared by the OCI memory controller
package debug_ocimem_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_RD, ST_DONE} state_e;
    localparam int JDO_W = 38;
    localparam int JDO_LOAD = 35;
    localparam int JDO_READ = 34;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    localparam int JDO_ADDR_LO = 17;
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADDEAD;
    function automatic logic [31:0] jdo_data(logic [JDO_W-1:0] j);
        return j[JDO_DATA_HI:JDO_DATA_LO];
    endfunction
endpackage

// File: rtl/debug_ocimem_ctrl_if.sv
// debug_ocimem_ctrl_if: word-addressed RAM bus with waitrequest and read-data-valid
interface debug_ocimem_ctrl_if #(parameter int ADDR_W = 9);
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_readdata;
    logic ram_read;
    logic ram_write;
    logic ram_waitrequest;
    logic ram_readdatavalid;
    modport master(
        output ram_addr, ram_wdata, ram_read, ram_write,
        input ram_waitrequest, ram_readdata, ram_readdatavalid
    );
    modport slave(
        input ram_addr, ram_wdata, ram_read, ram_write,
        output ram_waitrequest, ram_readdata, ram_readdatavalid
    );
endinterface

// File: rtl/debug_ocimem_timeout.sv
// debug_ocimem_timeout: clearable cycle counter; expired flags the TIMEOUT-th enabled cycle
module debug_ocimem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/debug_ocimem_ctrl.sv
// debug_ocimem_ctrl: executes JTAG debug read/write commands against the OCI RAM,
// tracking the current address (MonAReg) and the last data word (MonDReg)
module debug_ocimem_ctrl
    import debug_ocimem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    debug_ocimem_ctrl_if.master bus,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0] mon_d_q, mon_d_d, wdata_q, wdata_d;
    logic rd_q, rd_d, wr_q, wr_d, ready_q, ready_d, err_q, err_d, incr_q, incr_d;
    logic idle, any_cmd, collide, start_rd, start_wr, tmo_exp;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_LOAD+1], jdo[JDO_DATA_LO-1:0]};
    assign idle = state_q == ST_IDLE;
    assign any_cmd = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign collide = (take_action_ocimem_a & (take_no_action_ocimem_a | take_action_ocimem_b))
                   | (take_no_action_ocimem_a & take_action_ocimem_b);
    // command A wins any collision; B only runs when it arrives alone
    assign start_rd = idle & (take_action_ocimem_a ? jdo[JDO_READ] : take_no_action_ocimem_a);
    assign start_wr = idle & ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b;

    debug_ocimem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .reset_n(reset_n),
        .clr(state_q == ST_REQ),
        .en(state_q == ST_WAIT_RD),
        .expired(tmo_exp)
    );

    always_comb begin
        state_d = state_q;
        mon_a_d = mon_a_q;
        mon_d_d = mon_d_q;
        wdata_d = wdata_q;
        rd_d = rd_q;
        wr_d = wr_q;
        ready_d = ready_q;
        incr_d = incr_q;
        err_d = err_q;
        if (idle && take_action_ocimem_a && jdo[JDO_LOAD]) begin
            mon_a_d = jdo[JDO_ADDR_LO +: ADDR_W];
            err_d = 1'b0;
        end
        // setting the error outranks the clear from a colliding command A
        if ((!idle && any_cmd) || (idle && collide)) err_d = 1'b1;
        case (state_q)
            ST_IDLE: if (start_rd || start_wr) begin
                state_d = ST_REQ;
                rd_d = start_rd;
                wr_d = start_wr;
                ready_d = 1'b0;
                incr_d = ~take_action_ocimem_a;
                if (start_wr) begin
                    wdata_d = jdo_data(jdo);
                    mon_d_d = jdo_data(jdo);
                end
            end
            ST_REQ: if (!bus.ram_waitrequest) begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                state_d = rd_q ? ST_WAIT_RD : ST_DONE;
            end
            ST_WAIT_RD: if (bus.ram_readdatavalid) begin
                mon_d_d = bus.ram_readdata;
                state_d = ST_DONE;
            end else if (tmo_exp) begin
                mon_d_d = TIMEOUT_FILL;
                err_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                if (incr_q) mon_a_d = mon_a_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mon_a_q <= '0;
            mon_d_q <= '0;
            wdata_q <= '0;
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            ready_q <= 1'b1;
            err_q <= 1'b0;
            incr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            wdata_q <= wdata_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            ready_q <= ready_d;
            err_q <= err_d;
            incr_q <= incr_d;
        end
    end

    assign bus.ram_addr = mon_a_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_read = rd_q;
    assign bus.ram_write = wr_q;
    assign MonDReg = mon_d_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;
endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// tb_debug_ocimem_ctrl: directed vector table plus hand sequences for collisions, timeout and reset
module tb_debug_ocimem_ctrl;
    localparam int AW = 9;

    typedef struct {
        logic a, na, b, load, rd;
        logic [AW-1:0] addr;
        logic [31:0] data;
        int wt;
        logic resp;
        int lat;
        logic [31:0] dreg;
        logic [AW-1:0] areg;
        logic err;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic cmd_a = 1'b0, cmd_na = 1'b0, cmd_b = 1'b0;
    logic [31:0] mon_d;
    logic ready, err;

    debug_ocimem_ctrl_if #(.ADDR_W(AW)) bus();

    debug_ocimem_ctrl #(.ADDR_W(AW), .TIMEOUT(255)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .jdo(jdo),
        .take_action_ocimem_a(cmd_a),
        .take_no_action_ocimem_a(cmd_na),
        .take_action_ocimem_b(cmd_b),
        .bus(bus),
        .MonDReg(mon_d),
        .monitor_ready(ready),
        .monitor_error(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM model: reacts on the falling edge so the DUT sees stable inputs at the rising edge
    logic [31:0] mem [0:(1<<AW)-1];
    int wait_cycles = 0, wcnt = 0;
    logic resp_en = 1'b1, inject = 1'b0, pend_rd = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] log_a[$];
    logic [31:0] log_d[$];

    always @(negedge clk) begin
        bus.ram_readdatavalid = 1'b0;
        if (inject) begin
            bus.ram_readdatavalid = 1'b1;
            bus.ram_readdata = 32'h600DCAFE;
        end else if (pend_rd) begin
            bus.ram_readdatavalid = resp_en;
            bus.ram_readdata = mem[pend_addr];
        end
        pend_rd = 1'b0;
        if (bus.ram_read || bus.ram_write) begin
            if (wcnt < wait_cycles) begin
                bus.ram_waitrequest = 1'b1;
                wcnt++;
            end else begin
                bus.ram_waitrequest = 1'b0;
                wcnt = 0;
                if (bus.ram_write) begin
                    mem[bus.ram_addr] = bus.ram_wdata;
                    log_a.push_back(bus.ram_addr);
                    log_d.push_back(bus.ram_wdata);
                end else begin
                    pend_rd = 1'b1;
                    pend_addr = bus.ram_addr;
                end
            end
        end else begin
            bus.ram_waitrequest = 1'b0;
            wcnt = 0;
        end
    end

    always @(negedge clk) if (reset_n) chk("rw_exclusive", 32'(bus.ram_read & bus.ram_write), 32'd0);

    function automatic logic [37:0] mk_a(logic load, logic rd, logic [AW-1:0] addr);
        return {2'b00, load, rd, 8'h00, addr, 17'h0};
    endfunction

    function automatic vec_t mkv(logic a, logic na, logic b, logic load, logic rd, logic [AW-1:0] addr,
                                 logic [31:0] data, int wt, logic resp, int lat, logic [31:0] dreg,
                                 logic [AW-1:0] areg, logic e);
        vec_t v;
        v.a = a; v.na = na; v.b = b; v.load = load; v.rd = rd; v.addr = addr; v.data = data;
        v.wt = wt; v.resp = resp; v.lat = lat; v.dreg = dreg; v.areg = areg; v.err = e;
        return v;
    endfunction

    task automatic do_cmd(input logic a, input logic na, input logic b, input logic [37:0] j, output int lat);
        @(negedge clk);
        jdo = j; cmd_a = a; cmd_na = na; cmd_b = b;
        @(negedge clk);
        cmd_a = 1'b0; cmd_na = 1'b0; cmd_b = 1'b0;
        lat = 1;
        while (!ready && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_dreg"}, mon_d, 32'd0);
        chk({tag, "_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_read"}, 32'(bus.ram_read), 32'd0);
        chk({tag, "_write"}, 32'(bus.ram_write), 32'd0);
        chk({tag, "_wdata"}, bus.ram_wdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[13];
        int lat, n, nw0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[9'h010] = 32'h12345678;
        mem[9'h011] = 32'hCAFEF00D;
        mem[9'h020] = 32'h55AA55AA;
        mem[9'h040] = 32'h13579BDF;
        //             a  na b  ld rd addr    data wt rsp lat  dreg           areg    err
        vecs[0]  = mkv(1, 0, 0, 1, 1, 9'h010, 0,   0, 1,  4,   32'h12345678, 9'h010, 0);
        vecs[1]  = mkv(0, 1, 0, 0, 0, 9'h000, 0,   0, 1,  4,   32'h12345678, 9'h011, 0);
        vecs[2]  = mkv(0, 1, 0, 0, 0, 9'h000, 0,   0, 1,  4,   32'hCAFEF00D, 9'h012, 0);
        vecs[3]  = mkv(1, 0, 0, 1, 0, 9'h1FE, 0,   0, 1,  1,   32'hCAFEF00D, 9'h1FE, 0);
        vecs[4]  = mkv(0, 0, 1, 0, 0, 9'h000, 1,   2, 1,  5,   32'd1,        9'h1FF, 0);
        vecs[5]  = mkv(0, 0, 1, 0, 0, 9'h000, 2,   0, 1,  3,   32'd2,        9'h000, 0);
        vecs[6]  = mkv(0, 0, 1, 0, 0, 9'h000, 3,   0, 1,  3,   32'd3,        9'h001, 0);
        vecs[7]  = mkv(1, 0, 0, 1, 1, 9'h000, 0,   1, 1,  5,   32'd3,        9'h000, 0);
        vecs[8]  = mkv(1, 0, 0, 1, 0, 9'h1FF, 0,   0, 1,  1,   32'd3,        9'h1FF, 0);
        vecs[9]  = mkv(0, 1, 0, 0, 0, 9'h000, 0,   0, 1,  4,   32'd2,        9'h000, 0);
        vecs[10] = mkv(0, 1, 0, 0, 0, 9'h000, 0,   0, 0,  258, 32'hDEADDEAD, 9'h001, 1);
        vecs[11] = mkv(1, 0, 0, 1, 0, 9'h020, 0,   0, 1,  1,   32'hDEADDEAD, 9'h020, 0);
        vecs[12] = mkv(1, 0, 0, 0, 1, 9'h0AB, 0,   0, 1,  4,   32'h55AA55AA, 9'h020, 0);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            wait_cycles = vecs[i].wt;
            resp_en = vecs[i].resp;
            do_cmd(vecs[i].a, vecs[i].na, vecs[i].b,
                   vecs[i].b ? {3'b000, vecs[i].data, 3'b000} : mk_a(vecs[i].load, vecs[i].rd, vecs[i].addr), lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_mondreg", i), mon_d, vecs[i].dreg);
            chk($sformatf("v%0d_monareg", i), 32'(bus.ram_addr), 32'(vecs[i].areg));
            chk($sformatf("v%0d_error", i), 32'(err), 32'(vecs[i].err));
        end

        chk("burst_nwrites", 32'(log_a.size()), 32'd3);
        if (log_a.size() >= 3) begin
            chk("burst_w0_addr", 32'(log_a[0]), 32'h1FE);
            chk("burst_w0_data", log_d[0], 32'd1);
            chk("burst_w1_addr", 32'(log_a[1]), 32'h1FF);
            chk("burst_w1_data", log_d[1], 32'd2);
            chk("burst_w2_addr", 32'(log_a[2]), 32'h000);
            chk("burst_w2_data", log_d[2], 32'd3);
        end

        // command B while the streaming read sits in WAIT_RD
        nw0 = log_a.size();
        wait_cycles = 0;
        resp_en = 1'b0;
        @(negedge clk); cmd_na = 1'b1;
        @(negedge clk); cmd_na = 1'b0;
        @(negedge clk); cmd_b = 1'b1; jdo = {3'b000, 32'h77, 3'b000};
        @(posedge clk); #1 cmd_b = 1'b0; inject = 1'b1;
        @(posedge clk); #1 inject = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_ready", 32'(ready), 32'd1);
        chk("busy_error", 32'(err), 32'd1);
        chk("busy_mondreg", mon_d, 32'h600DCAFE);
        chk("busy_monareg", 32'(bus.ram_addr), 32'h021);
        chk("busy_nowrite", 32'(log_a.size()), 32'(nw0));

        resp_en = 1'b1;
        do_cmd(1, 0, 0, mk_a(1, 0, 9'h030), lat);
        chk("clear_error", 32'(err), 32'd0);
        chk("clear_monareg", 32'(bus.ram_addr), 32'h030);

        // A and B together while idle: A runs, B is dropped
        do_cmd(1, 0, 1, mk_a(1, 1, 9'h040), lat);
        chk("ab_latency", 32'(lat), 32'd4);
        chk("ab_error", 32'(err), 32'd1);
        chk("ab_mondreg", mon_d, 32'h13579BDF);
        chk("ab_monareg", 32'(bus.ram_addr), 32'h040);
        chk("ab_nowrite", 32'(log_a.size()), 32'(nw0));

        // reset while the read is stalled in REQ, then a stale valid afterwards
        wait_cycles = 10;
        @(negedge clk); cmd_na = 1'b1;
        @(negedge clk); cmd_na = 1'b0;
        chk("midrd_in_req", 32'(bus.ram_read), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrd_async");
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1 inject = 1'b1;
        @(posedge clk); #1 inject = 1'b0;
        @(negedge clk);
        check_reset_outputs("stale_valid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_ocimem_ctrl.md
DEBUG_OCIMEM_CTRL -- requirements
Module: debug_ocimem_ctrl

Interface
REQ-001 The block SHALL have one clock, `clk`; reset is asynchronous and active-low, named `reset_n`.
REQ-002 Parameter ADDR_W, default 9: RAM word-address width.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for read data.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 jdo  in  38  debug command/data word from the JTAG sysclk stage.
REQ-007 take_action_ocimem_a  in  1  single-cycle pulse: command A (load address and/or read).
REQ-008 take_no_action_ocimem_a  in  1  single-cycle pulse: streaming read at current address.
REQ-009 take_action_ocimem_b  in  1  single-cycle pulse: write jdo[34:3] at current address.
REQ-010 ram_addr  out  ADDR_W  RAM word address.
REQ-011 ram_wdata  out  32  RAM write data.
REQ-012 ram_read / ram_write  out  1 each  RAM request strobes.
REQ-013 ram_waitrequest  in  1  RAM stall; a request is accepted on the first cycle it is low.
REQ-014 ram_readdata  in  32  RAM read data.
REQ-015 ram_readdatavalid  in  1  qualifies ram_readdata.
REQ-016 MonDReg  out  32  last read data, or last write data.
REQ-017 monitor_ready  out  1  high when idle and able to accept a command.
REQ-018 monitor_error  out  1  sticky error flag.

Function
REQ-019 The FSM SHALL have four states:
- IDLE: accepts commands.
- REQ: holds ram_read or ram_write until ram_waitrequest is low.
- WAIT_RD: waits for ram_readdatavalid.
- DONE: one cycle; updates registers and returns to IDLE.
REQ-020 Command A with jdo[35]=1 SHALL load MonAReg <= jdo[ADDR_W+16:17] in the same cycle.
REQ-021 Command A with jdo[34]=1 SHALL start a read at the newly loaded (or current) address; with jdo[34]=0 it SHALL stay in IDLE.
REQ-022 Streaming read and write commands SHALL use MonAReg, then post-increment it in DONE.
REQ-023 MonAReg SHALL wrap from 2^ADDR_W-1 to 0 with no error.
REQ-024 Command A does not increment MonAReg.
REQ-025 On write, MonDReg <= jdo[34:3] and ram_wdata <= jdo[34:3] when the command is accepted.
REQ-026 On read, MonDReg <= ram_readdata in the cycle ram_readdatavalid is high.
REQ-027 Minimum latency with ram_waitrequest=0 and read data one cycle after acceptance:
- read: command to monitor_ready high again = 4 cycles;
- write: 3 cycles.
REQ-028 monitor_ready SHALL be low from the cycle after command acceptance until the cycle after DONE.
REQ-029 A command arriving while not in IDLE SHALL be ignored and SHALL set monitor_error.
REQ-030 If command A and command B arrive in the same cycle, command A SHALL be executed, B dropped, and monitor_error set.
REQ-031 WAIT_RD SHALL count cycles. When the count reaches TIMEOUT without ram_readdatavalid:
- monitor_error is set;
- MonDReg <= 32'hDEADDEAD;
- MonAReg still increments (streaming case only);
- the FSM goes to DONE.
REQ-032 A ram_readdatavalid arriving outside WAIT_RD SHALL be ignored.
REQ-033 monitor_error SHALL clear only on command A with jdo[35]=1, or on reset.
REQ-034 ram_addr SHALL equal MonAReg; ram_read and ram_write SHALL never be high together.

Reset
REQ-035 On reset_n low, asynchronously and regardless of state:
- FSM = IDLE;
- MonAReg = 0, MonDReg = 0, timeout counter = 0;
- ram_read = 0, ram_write = 0, ram_wdata = 0;
- monitor_ready = 1, monitor_error = 0.
REQ-036 Reset mid-transaction SHALL abandon the transaction; later stale ram_readdatavalid is ignored per REQ-032.

Structure
REQ-037 The shared package SHALL hold:
- the FSM state enum;
- jdo bit-position constants (35 load, 34 read, 34:3 data, ADDR_W+16:17 address);
- TIMEOUT_FILL = 32'hDEADDEAD.
REQ-038 One sub-module, debug_ocimem_timeout, SHALL implement the loadable timeout counter (clear, enable, expired).

Verification
REQ-039 Load-and-read: command A with jdo[35]=1, address 0x010, jdo[34]=1; RAM returns 0x12345678 one cycle later → MonDReg=0x12345678, MonAReg=0x010, monitor_ready high 4 cycles after the command.
REQ-040 Write burst: three command B pulses with data 1, 2, 3 starting at 0x1FE, ram_waitrequest high for 2 cycles on the first → writes land at 0x1FE, 0x1FF, 0x000; MonAReg=0x001.
REQ-041 Timeout: streaming read with ram_readdatavalid never asserted → after 255 WAIT_RD cycles, MonDReg=0xDEADDEAD, monitor_error=1, MonAReg incremented by 1.
REQ-042 Collision: command B while in WAIT_RD, then command A and B in the same cycle while idle → both flagged in monitor_error, no extra RAM write; error cleared by the next command A with jdo[35]=1.
REQ-043 Reset mid-read: reset_n low while in REQ, then release; inject a stale ram_readdatavalid → all outputs at reset values, MonDReg stays 0.
